// File: rtl/pll_seq_pkg.sv
// Shared state encoding and constant helpers for the PLL lock sequencer.
package pll_seq_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } pll_state_e;

  // Largest of three values; sizes the shared timer.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchroniser, synchronous active-high reset to 0.
module sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of an asynchronous level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses RESETB, waits for a qualified lock with
// timeout and retry limit, and holds the design in reset until lock is stable.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 12000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pll_lock,
  input  logic             relock_req,
  output logic             pll_resetb,
  output logic             sys_reset,
  output logic             locked,
  output logic             fail,
  output logic [CNT_W-1:0] loss_count
);

  localparam int unsigned TIMER_W = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1;
  localparam int unsigned RET_W   = $clog2(MAX_RETRIES + 1);

  pll_state_e         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [RET_W-1:0]   retries_q, retries_d;
  logic [CNT_W-1:0]   loss_q, loss_d;
  logic               pll_resetb_q, pll_resetb_d;
  logic               sys_reset_q, sys_reset_d;
  logic               locked_q, locked_d;
  logic               fail_q, fail_d;
  logic               lk;

  sync2 u_lock_sync (
    .clk_i (clock),
    .rst_i (reset),
    .d_i   (pll_lock),
    .q_o   (lk)
  );

  // State, timer, counters and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= PLL_RST;
      timer_q      <= '0;
      retries_q    <= '0;
      loss_q       <= '0;
      pll_resetb_q <= 1'b0;
      sys_reset_q  <= 1'b1;
      locked_q     <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      retries_q    <= retries_d;
      loss_q       <= loss_d;
      pll_resetb_q <= pll_resetb_d;
      sys_reset_q  <= sys_reset_d;
      locked_q     <= locked_d;
      fail_q       <= fail_d;
    end
  end

  // Next-state logic; relock beats lock drop, which beats timer expiry.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + TIMER_W'(1);
    retries_d = retries_q;
    loss_d    = loss_q;

    if (relock_req) begin
      state_d   = PLL_RST;
      timer_d   = '0;
      retries_d = '0;
    end else begin
      unique case (state_q)
        PLL_RST: begin
          if (timer_q == TIMER_W'(RST_CYCLES - 1)) begin
            state_d = WAIT_LOCK;
            timer_d = '0;
          end
        end
        WAIT_LOCK: begin
          if (lk) begin
            state_d = STABLE;
            timer_d = '0;
          end else if (timer_q == TIMER_W'(LOCK_TIMEOUT - 1)) begin
            retries_d = retries_q + RET_W'(1);
            timer_d   = '0;
            state_d   = (retries_d == RET_W'(MAX_RETRIES)) ? FAIL : PLL_RST;
          end
        end
        STABLE: begin
          if (!lk) begin
            state_d = WAIT_LOCK;
            timer_d = '0;
          end else if (timer_q == TIMER_W'(STABLE_CYCLES - 1)) begin
            state_d   = RUN;
            timer_d   = '0;
            retries_d = '0;
          end
        end
        RUN: begin
          timer_d = '0;
          // The PLL relocks on its own; only the design reset is re-applied.
          if (!lk) begin
            state_d = WAIT_LOCK;
            if (loss_q != '1) begin
              loss_d = loss_q + CNT_W'(1);
            end
          end
        end
        FAIL: begin
          timer_d = '0;
        end
        default: begin
          state_d = PLL_RST;
          timer_d = '0;
        end
      endcase
    end

    pll_resetb_d = (state_d != PLL_RST);
    sys_reset_d  = (state_d != RUN);
    locked_d     = (state_d == RUN);
    fail_d       = (state_d == FAIL);
  end

  assign pll_resetb = pll_resetb_q;
  assign sys_reset  = sys_reset_q;
  assign locked     = locked_q;
  assign fail       = fail_q;
  assign loss_count = loss_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: segment table plus corner-case sequences.
module tb_pll_lock_sequencer;
  import pll_seq_pkg::*;

  localparam int S_RST  = int'(PLL_RST);
  localparam int S_WAIT = int'(WAIT_LOCK);
  localparam int S_STB  = int'(STABLE);
  localparam int S_RUN  = int'(RUN);
  localparam int S_FAIL = int'(FAIL);

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       pll_lock = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_resetb, sys_reset, locked, fail;
  logic [7:0] loss_count;
  logic       pll_resetb2, sys_reset2, locked2, fail2;
  logic [1:0] loss_count2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int rst; int lock; int relock; int cycles;
    int resetb; int sysrst; int lkd; int fl; int loss; int st; int ret;
  } vec_t;

  vec_t vecs[$];

  always #5 clock = ~clock;

  pll_lock_sequencer #(.RST_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8),
                       .MAX_RETRIES(2), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .pll_lock(pll_lock), .relock_req(relock_req),
    .pll_resetb(pll_resetb), .sys_reset(sys_reset), .locked(locked), .fail(fail),
    .loss_count(loss_count));

  pll_lock_sequencer #(.RST_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8),
                       .MAX_RETRIES(2), .CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .pll_lock(pll_lock), .relock_req(relock_req),
    .pll_resetb(pll_resetb2), .sys_reset(sys_reset2), .locked(locked2), .fail(fail2),
    .loss_count(loss_count2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input int r, input int l, input int q, input int n,
                     input int eb, input int es, input int el, input int ef,
                     input int loss, input int st, input int ret);
    vec_t v;
    v.rst = r; v.lock = l; v.relock = q; v.cycles = n;
    v.resetb = eb; v.sysrst = es; v.lkd = el; v.fl = ef;
    v.loss = loss; v.st = st; v.ret = ret;
    vecs.push_back(v);
  endtask

  task automatic wait_locked(input int budget, input string name);
    int n = 0;
    while (locked !== 1'b1 && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk(name, 32'(locked), 32'd1);
  endtask

  task automatic wait_fail(input int budget, input string name);
    int n = 0;
    while (fail !== 1'b1 && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk(name, 32'(fail), 32'd1);
  endtask

  // Registered status outputs must always agree with the current state.
  always @(negedge clock) begin
    chk("inv_sys_reset", 32'(sys_reset), 32'(dut.state_q != RUN));
    chk("inv_locked", 32'(locked), 32'(dut.state_q == RUN));
    chk("inv_fail", 32'(fail), 32'(dut.state_q == FAIL));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Bring-up, then a 3-cycle loss in RUN.
    add(1,0,0,3,  0,1,0,0,0,S_RST,0);
    add(0,0,0,3,  0,1,0,0,0,S_RST,0);
    add(0,0,0,1,  1,1,0,0,0,S_WAIT,0);
    add(0,0,0,9,  1,1,0,0,0,S_WAIT,0);
    add(0,1,0,2,  1,1,0,0,0,S_WAIT,0);
    add(0,1,0,1,  1,1,0,0,0,S_STB,0);
    add(0,1,0,7,  1,1,0,0,0,S_STB,0);
    add(0,1,0,1,  1,0,1,0,0,S_RUN,0);
    add(0,0,0,2,  1,0,1,0,0,S_RUN,0);
    add(0,0,0,1,  1,1,0,0,1,S_WAIT,0);
    add(0,1,0,2,  1,1,0,0,1,S_WAIT,0);
    add(0,1,0,1,  1,1,0,0,1,S_STB,0);
    add(0,1,0,7,  1,1,0,0,1,S_STB,0);
    add(0,1,0,1,  1,0,1,0,1,S_RUN,0);
    // Lock never arrives: two pulses, two timeouts, FAIL.
    add(1,0,0,2,  0,1,0,0,0,S_RST,0);
    add(0,0,0,3,  0,1,0,0,0,S_RST,0);
    add(0,0,0,1,  1,1,0,0,0,S_WAIT,0);
    add(0,0,0,19, 1,1,0,0,0,S_WAIT,0);
    add(0,0,0,1,  0,1,0,0,0,S_RST,1);
    add(0,0,0,3,  0,1,0,0,0,S_RST,1);
    add(0,0,0,1,  1,1,0,0,0,S_WAIT,1);
    add(0,0,0,19, 1,1,0,0,0,S_WAIT,1);
    add(0,0,0,1,  1,1,0,1,0,S_FAIL,2);
    add(0,0,0,10, 1,1,0,1,0,S_FAIL,2);
    // One timeout, then glitches in STABLE (mid-window and last cycle).
    add(1,0,0,2,  0,1,0,0,0,S_RST,0);
    add(0,0,0,4,  1,1,0,0,0,S_WAIT,0);
    add(0,0,0,20, 0,1,0,0,0,S_RST,1);
    add(0,0,0,4,  1,1,0,0,0,S_WAIT,1);
    add(0,1,0,2,  1,1,0,0,0,S_WAIT,1);
    add(0,1,0,1,  1,1,0,0,0,S_STB,1);
    add(0,1,0,2,  1,1,0,0,0,S_STB,1);
    add(0,0,0,1,  1,1,0,0,0,S_STB,1);
    add(0,1,0,1,  1,1,0,0,0,S_STB,1);
    add(0,1,0,1,  1,1,0,0,0,S_WAIT,1);
    add(0,1,0,1,  1,1,0,0,0,S_STB,1);
    add(0,1,0,5,  1,1,0,0,0,S_STB,1);
    add(0,0,0,1,  1,1,0,0,0,S_STB,1);
    add(0,1,0,1,  1,1,0,0,0,S_STB,1);
    add(0,1,0,1,  1,1,0,0,0,S_WAIT,1);
    add(0,1,0,1,  1,1,0,0,0,S_STB,1);
    add(0,1,0,7,  1,1,0,0,0,S_STB,1);
    add(0,1,0,1,  1,0,1,0,0,S_RUN,0);

    foreach (vecs[i]) begin
      reset      = (vecs[i].rst != 0);
      pll_lock   = (vecs[i].lock != 0);
      relock_req = (vecs[i].relock != 0);
      repeat (vecs[i].cycles) @(negedge clock);
      chk($sformatf("row%0d_resetb", i), 32'(pll_resetb), 32'(vecs[i].resetb));
      chk($sformatf("row%0d_sysrst", i), 32'(sys_reset), 32'(vecs[i].sysrst));
      chk($sformatf("row%0d_locked", i), 32'(locked), 32'(vecs[i].lkd));
      chk($sformatf("row%0d_fail", i), 32'(fail), 32'(vecs[i].fl));
      chk($sformatf("row%0d_loss", i), 32'(loss_count), 32'(vecs[i].loss));
      chk($sformatf("row%0d_state", i), 32'(dut.state_q), 32'(vecs[i].st));
      chk($sformatf("row%0d_retries", i), 32'(dut.retries_q), 32'(vecs[i].ret));
    end

    // Loss-count saturation: five losses, 8-bit and 2-bit counters.
    reset = 1'b1; pll_lock = 1'b1; relock_req = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    wait_locked(100, "bringup_locked");
    for (int i = 0; i < 5; i++) begin
      pll_lock = 1'b0;
      repeat (3) @(negedge clock);
      chk($sformatf("loss%0d_sysrst", i), 32'(sys_reset), 32'd1);
      pll_lock = 1'b1;
      repeat (11) @(negedge clock);
      chk($sformatf("loss%0d_relocked", i), 32'(locked), 32'd1);
      chk($sformatf("loss%0d_pll_resetb", i), 32'(pll_resetb), 32'd1);
      chk($sformatf("loss%0d_cnt8", i), 32'(loss_count), 32'(i + 1));
      chk($sformatf("loss%0d_cnt2", i), 32'(loss_count2), 32'((i + 1 > 3) ? 3 : i + 1));
    end

    // relock_req coinciding with the lk drop seen in RUN.
    pll_lock = 1'b0;
    repeat (2) @(negedge clock);
    chk("prio_pre_run", 32'(locked), 32'd1);
    relock_req = 1'b1;
    @(negedge clock);
    relock_req = 1'b0;
    chk("prio_state", 32'(dut.state_q), 32'(S_RST));
    chk("prio_resetb", 32'(pll_resetb), 32'd0);
    chk("prio_cnt8", 32'(loss_count), 32'd5);
    chk("prio_cnt2", 32'(loss_count2), 32'd3);

    // Recovery from FAIL, pulse restart, then reset mid-WAIT_LOCK.
    wait_fail(100, "reach_fail");
    chk("fail_sysrst", 32'(sys_reset), 32'd1);
    relock_req = 1'b1;
    @(negedge clock);
    relock_req = 1'b0;
    chk("recover_fail", 32'(fail), 32'd0);
    chk("recover_resetb", 32'(pll_resetb), 32'd0);
    chk("recover_retries", 32'(dut.retries_q), 32'd0);
    @(negedge clock);
    relock_req = 1'b1;
    @(negedge clock);
    relock_req = 1'b0;
    repeat (3) @(negedge clock);
    chk("restart_still_low", 32'(pll_resetb), 32'd0);
    @(negedge clock);
    chk("restart_release", 32'(pll_resetb), 32'd1);
    chk("restart_wait", 32'(dut.state_q), 32'(S_WAIT));
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rst_resetb", 32'(pll_resetb), 32'd0);
    chk("rst_sysrst", 32'(sys_reset), 32'd1);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_fail", 32'(fail), 32'd0);
    chk("rst_cnt8", 32'(loss_count), 32'd0);
    chk("rst_cnt2", 32'(loss_count2), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(S_RST));
    chk("rst_timer", 32'(dut.timer_q), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
